// File: rtl/ay8913_mixer.sv
`default_nettype none
// ============================================================================
// Module   : ay8913_mixer
// Purpose  : AY-3-8913 mixer stage feeding the PDM DAC. On each sample_tick
//            the tone/noise/amplitude inputs are captured into shadow
//            registers. Each channel is then gated by the AY mixer-enable
//            rules and mapped through a logarithmic volume table. The three
//            channels are accumulated serially over three clocks and the
//            sum is presented left-aligned on value_out.
// Ports    : clk, rst_n (async active-low)
//            sample_tick            - strobe requesting a new mix
//            tone[2:0], noise       - generator outputs (bit0 = A)
//            tone_disable[2:0]      - per-channel tone disable (1 = off)
//            noise_disable[2:0]     - per-channel noise disable (1 = off)
//            amp_a/b/c[4:0]         - [4] envelope mode, [3:0] fixed level
//            envelope[3:0]          - current envelope level
//            value_out[VALUE_BITS]  - mixed level, held between updates
//            value_valid            - one-cycle pulse on update
//            busy                   - mix in progress
//            overrun                - one-cycle pulse when a tick is dropped
// Revision : 1.0 - initial release
// ============================================================================
module ay8913_mixer #(
  parameter int VALUE_BITS = 8  // must be >= 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [2:0]            tone,
  input  logic                  noise,
  input  logic [2:0]            tone_disable,
  input  logic [2:0]            noise_disable,
  input  logic [4:0]            amp_a,
  input  logic [4:0]            amp_b,
  input  logic [4:0]            amp_c,
  input  logic [3:0]            envelope,
  output logic [VALUE_BITS-1:0] value_out,
  output logic                  value_valid,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH_A = 2'd1,
    CH_B = 2'd2,
    CH_C = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            acc_q, acc_d;
  logic [2:0]            tone_q, tone_d;
  logic                  noise_q, noise_d;
  logic [2:0]            tdis_q, tdis_d;
  logic [2:0]            ndis_q, ndis_d;
  logic [4:0]            amp_a_q, amp_a_d;
  logic [4:0]            amp_b_q, amp_b_d;
  logic [4:0]            amp_c_q, amp_c_d;
  logic [3:0]            env_q, env_d;
  logic [VALUE_BITS-1:0] value_out_q, value_out_d;
  logic                  value_valid_q, value_valid_d;
  logic                  overrun_q, overrun_d;

  logic [6:0]            vol_w;
  logic [7:0]            sum_w;

  // Logarithmic volume table, 16 levels, max 85 so three channels fit 8 bits.
  function automatic logic [6:0] vol_lut(input logic [3:0] level);
    case (level)
      4'd0:  vol_lut = 7'd0;
      4'd1:  vol_lut = 7'd1;
      4'd2:  vol_lut = 7'd1;
      4'd3:  vol_lut = 7'd1;
      4'd4:  vol_lut = 7'd2;
      4'd5:  vol_lut = 7'd3;
      4'd6:  vol_lut = 7'd4;
      4'd7:  vol_lut = 7'd5;
      4'd8:  vol_lut = 7'd8;
      4'd9:  vol_lut = 7'd11;
      4'd10: vol_lut = 7'd15;
      4'd11: vol_lut = 7'd21;
      4'd12: vol_lut = 7'd30;
      4'd13: vol_lut = 7'd43;
      4'd14: vol_lut = 7'd60;
      default: vol_lut = 7'd85;
    endcase
  endfunction

  // A disabled source forces its gate term high, so with both sources
  // disabled the channel outputs a constant level (AY DC behaviour).
  function automatic logic [6:0] chan_vol(
    input logic       t,
    input logic       td,
    input logic       n,
    input logic       nd,
    input logic [4:0] amp,
    input logic [3:0] env
  );
    logic       gate;
    logic [3:0] level;
    gate     = (t | td) & (n | nd);
    level    = amp[4] ? env : amp[3:0];
    chan_vol = gate ? vol_lut(level) : 7'd0;
  endfunction

  // Volume of the channel handled in the current state, from shadow copies.
  always_comb begin
    vol_w = 7'd0;
    case (state_q)
      CH_A:    vol_w = chan_vol(tone_q[0], tdis_q[0], noise_q, ndis_q[0], amp_a_q, env_q);
      CH_B:    vol_w = chan_vol(tone_q[1], tdis_q[1], noise_q, ndis_q[1], amp_b_q, env_q);
      CH_C:    vol_w = chan_vol(tone_q[2], tdis_q[2], noise_q, ndis_q[2], amp_c_q, env_q);
      default: vol_w = 7'd0;
    endcase
  end

  assign sum_w = acc_q + {1'b0, vol_w};

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    tone_d        = tone_q;
    noise_d       = noise_q;
    tdis_d        = tdis_q;
    ndis_d        = ndis_q;
    amp_a_d       = amp_a_q;
    amp_b_d       = amp_b_q;
    amp_c_d       = amp_c_q;
    env_d         = env_q;
    value_out_d   = value_out_q;
    value_valid_d = 1'b0;
    // A tick arriving mid-mix is dropped and flagged; the mix continues.
    overrun_d     = sample_tick && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          tone_d  = tone;
          noise_d = noise;
          tdis_d  = tone_disable;
          ndis_d  = noise_disable;
          amp_a_d = amp_a;
          amp_b_d = amp_b;
          amp_c_d = amp_c;
          env_d   = envelope;
          acc_d   = 8'd0;
          state_d = CH_A;
        end
      end
      CH_A: begin
        acc_d   = sum_w;
        state_d = CH_B;
      end
      CH_B: begin
        acc_d   = sum_w;
        state_d = CH_C;
      end
      CH_C: begin
        // Left-align the 8-bit sum into the wider DAC value.
        value_out_d   = VALUE_BITS'(sum_w) << (VALUE_BITS - 8);
        value_valid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= 8'd0;
      tone_q        <= 3'd0;
      noise_q       <= 1'b0;
      tdis_q        <= 3'd0;
      ndis_q        <= 3'd0;
      amp_a_q       <= 5'd0;
      amp_b_q       <= 5'd0;
      amp_c_q       <= 5'd0;
      env_q         <= 4'd0;
      value_out_q   <= '0;
      value_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      tone_q        <= tone_d;
      noise_q       <= noise_d;
      tdis_q        <= tdis_d;
      ndis_q        <= ndis_d;
      amp_a_q       <= amp_a_d;
      amp_b_q       <= amp_b_d;
      amp_c_q       <= amp_c_d;
      env_q         <= env_d;
      value_out_q   <= value_out_d;
      value_valid_q <= value_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign value_out   = value_out_q;
  assign value_valid = value_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ay8913_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ay8913_mixer
// Purpose  : Self-checking bench for ay8913_mixer. Drives an 8-bit and a
//            10-bit instance from shared inputs and compares both against a
//            behavioural model of the AY mixer/volume rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ay8913_mixer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic [2:0] tone;
  logic       noise;
  logic [2:0] tone_disable;
  logic [2:0] noise_disable;
  logic [4:0] amp_a, amp_b, amp_c;
  logic [3:0] envelope;

  logic [7:0] v8;
  logic       valid8, busy8, ovr8;
  logic [9:0] v10;
  logic       valid10, busy10, ovr10;

  int checks = 0;
  int errors = 0;

  int LUT[16] = '{0, 1, 1, 1, 2, 3, 4, 5, 8, 11, 15, 21, 30, 43, 60, 85};

  always #5 clk = ~clk;

  ay8913_mixer #(.VALUE_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .tone(tone),
    .noise(noise), .tone_disable(tone_disable), .noise_disable(noise_disable),
    .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c), .envelope(envelope),
    .value_out(v8), .value_valid(valid8), .busy(busy8), .overrun(ovr8)
  );

  ay8913_mixer #(.VALUE_BITS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .tone(tone),
    .noise(noise), .tone_disable(tone_disable), .noise_disable(noise_disable),
    .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c), .envelope(envelope),
    .value_out(v10), .value_valid(valid10), .busy(busy10), .overrun(ovr10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mixed sum of the current inputs, straight from the mixer rules.
  function automatic int model_sum();
    int s = 0;
    for (int ch = 0; ch < 3; ch++) begin
      logic [4:0] amp;
      int         lvl;
      amp = (ch == 0) ? amp_a : (ch == 1) ? amp_b : amp_c;
      lvl = amp[4] ? int'(envelope) : int'(amp[3:0]);
      if ((tone[ch] || tone_disable[ch]) && (noise || noise_disable[ch]))
        s += LUT[lvl];
    end
    return s;
  endfunction

  task automatic set_in(input logic [2:0] t, input logic n, input logic [2:0] td,
                        input logic [2:0] nd, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [3:0] e);
    tone = t; noise = n; tone_disable = td; noise_disable = nd;
    amp_a = a; amp_b = b; amp_c = c; envelope = e;
  endtask

  task automatic scramble();
    set_in(3'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
  endtask

  // One full mix: tick sampled at E0, result checked just after E3, then
  // inputs are scrambled after capture to prove shadowing.
  task automatic run_mix(input string tag);
    int exp;
    exp = model_sum();
    sample_tick = 1'b1;
    @(posedge clk); #1;                       // E0
    sample_tick = 1'b0;
    scramble();
    chk({tag, "_busy"}, busy8, 1);
    @(posedge clk); #1;                       // E1
    chk({tag, "_valid_e1"}, valid8, 0);
    @(posedge clk); #1;                       // E2
    chk({tag, "_valid_e2"}, valid8, 0);
    @(posedge clk); #1;                       // E3
    chk({tag, "_valid_e3"}, valid8, 1);
    chk({tag, "_v8"}, v8, exp);
    chk({tag, "_v10"}, v10, exp * 4);
    chk({tag, "_idle"}, busy8, 0);
    @(posedge clk); #1;                       // E3+1
    chk({tag, "_valid_e4"}, valid8, 0);
    chk({tag, "_hold"}, v8, exp);
  endtask

  initial begin
    int cnt_valid, cnt_ovr, exp;

    // 1. Reset with random inputs held
    rst_n = 1'b0;
    sample_tick = 1'($urandom);
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v8_in", v8, 0);
    chk("rst_busy_in", busy8, 0);
    sample_tick = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_v8", v8, 0);
    chk("rst_v10", v10, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_ovr", ovr8, 0);

    // 2. Full scale
    set_in(3'b111, 1'b1, 3'b000, 3'b000, 5'h0F, 5'h0F, 5'h0F, 4'h0);
    run_mix("full");

    // 1b. Reset during CH_B aborts the mix
    set_in(3'b111, 1'b1, 3'b000, 3'b000, 5'h0A, 5'h0B, 5'h0C, 4'h0);
    sample_tick = 1'b1;
    @(posedge clk); #1;                       // E0
    sample_tick = 1'b0;
    @(posedge clk); #1;                       // E1: now in CH_B
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_v8", v8, 0);
    chk("midrst_valid", valid8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid8) cnt_valid++;
    end
    chk("midrst_no_valid", cnt_valid, 0);

    // 3. Gating and DC
    set_in(3'b000, 1'b1, 3'b000, 3'b000, 5'h0C, 5'h00, 5'h00, 4'h0);
    run_mix("gate_off");
    chk("gate_off_zero", v8, 0);
    set_in(3'b000, 1'b1, 3'b001, 3'b001, 5'h0C, 5'h00, 5'h00, 4'h0);
    run_mix("dc");
    chk("dc_30", v8, 30);

    // 4. Envelope select (envelope scrambled after capture inside run_mix)
    set_in(3'b010, 1'b1, 3'b000, 3'b000, 5'h00, 5'h10, 5'h00, 4'hD);
    run_mix("env");
    chk("env_43", v8, 43);

    // 5a. Overrun: second tick sampled at E2
    set_in(3'b111, 1'b1, 3'b000, 3'b000, 5'h05, 5'h06, 5'h07, 4'h0);
    exp = model_sum();
    sample_tick = 1'b1;
    @(posedge clk); #1;                       // E0
    sample_tick = 1'b0;
    @(posedge clk); #1;                       // E1
    chk("ovr_pre", ovr8, 0);
    sample_tick = 1'b1;
    @(posedge clk); #1;                       // E2
    sample_tick = 1'b0;
    chk("ovr_pulse", ovr8, 1);
    chk("ovr_pulse10", ovr10, 1);
    @(posedge clk); #1;                       // E3
    chk("ovr_clear", ovr8, 0);
    chk("ovr_valid", valid8, 1);
    chk("ovr_value", v8, exp);
    cnt_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (valid8) cnt_valid++;
      if (busy8) cnt_valid += 100;
    end
    chk("ovr_single_valid", cnt_valid, 0);

    // 5b. Twenty ticks spaced 4 cycles, random inputs
    cnt_valid = 0;
    cnt_ovr = 0;
    for (int s = 0; s < 20; s++) begin
      scramble();
      exp = model_sum();
      sample_tick = 1'b1;
      @(posedge clk); #1;                     // E0
      sample_tick = 1'b0;
      scramble();
      for (int k = 0; k < 3; k++) begin
        if (valid8) cnt_valid++;
        if (ovr8) cnt_ovr++;
        @(posedge clk); #1;
      end
      if (valid8) cnt_valid++;
      if (ovr8) cnt_ovr++;
      chk("stream_value", v8, exp);
      chk("stream_value10", v10, exp * 4);
    end
    @(posedge clk); #1;
    if (valid8) cnt_valid++;
    if (ovr8) cnt_ovr++;
    chk("stream_valid_count", cnt_valid, 20);
    chk("stream_ovr_count", cnt_ovr, 0);

    // 6. LUT sweep on channel A
    for (int l = 0; l < 16; l++) begin
      set_in(3'b001, 1'b1, 3'b000, 3'b000, 5'(l), 5'h00, 5'h00, 4'h0);
      run_mix("lut");
      chk("lut_table", v8, LUT[l]);
    end

    // Random full mixes
    for (int r = 0; r < 8; r++) begin
      scramble();
      run_mix("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
